noc_output_rr_arbiter: RTL and testbench

Round-robin packet arbiter for one router output port. It shares that port between the five router inputs (N, S, W, E, L). A grant is locked for the length of a wormhole packet, and priority rotates only at packet boundaries. It drives the one-hot grant and 3-bit crossbar select consumed by the output crossbar and switch-allocation logic. A hold watchdog stops a stuck packet from owning the port.

---
 rtl/noc_output_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_noc_output_rr_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_rr_arbiter.sv
// noc_output_rr_arbiter
//   Round-robin packet arbiter for one router output port. It is shared by
//   five inputs (N, S, W, E, L). A grant stays locked for a whole wormhole
//   packet. Priority rotates only when a packet is released. A hold watchdog
//   force-releases a packet that keeps the port too long.
// Ports
//   clk_i, rst_n_i  clock, async active-low reset
//   req_i[4:0]      requests, [4]=N [3]=S [2]=W [1]=E [0]=L
//   tail_i          granted input's current flit is a tail
//   out_ready_i     downstream can take a flit this cycle
//   grant_o[4:0]    one-hot grant (registered), same order as req_i
//   grant_sel_o     crossbar select N=0..L=4 (registered), 0 when idle
//   grant_valid_o   grant held (registered)
//   fire_o          flit transfers this cycle (combinational)
//   timeout_o       one-cycle pulse after a watchdog release (registered)
module noc_output_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 64,
  parameter int unsigned CNT_W    = 7
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [4:0] req_i,
  input  logic       tail_i,
  input  logic       out_ready_i,
  output logic [4:0] grant_o,
  output logic [2:0] grant_sel_o,
  output logic       grant_valid_o,
  output logic       fire_o,
  output logic       timeout_o
);

  localparam int unsigned NUM_IN = 5;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SUM_W  = IDX_W + 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [CNT_W-1:0]    hcnt_q, hcnt_d;
  logic [NUM_IN-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;

  logic [NUM_IN-1:0]   req_idx;
  logic [IDX_W-1:0]    nxt_ptr;
  logic [IDX_W:0]      idle_pick;
  logic [IDX_W:0]      rel_pick;
  logic                rel;
  logic                rel_timeout;

  // First requester at or after ptr, wrapping mod NUM_IN; {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [IDX_W-1:0] ptr,
                                             input logic [NUM_IN-1:0] req);
    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] win;
    logic             found;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sum = SUM_W'(ptr) + SUM_W'(i);
      if (sum >= SUM_W'(NUM_IN)) sum = sum - SUM_W'(NUM_IN);
      if (!found && req[sum[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = sum[IDX_W-1:0];
      end
    end
    return {found, win};
  endfunction

  // Reorder requests so bit k is input index k (N=0 .. L=4).
  always_comb begin
    req_idx = '0;
    for (int k = 0; k < NUM_IN; k++) req_idx[k] = req_i[NUM_IN-1-k];
  end

  assign nxt_ptr   = (gidx_q == IDX_W'(NUM_IN-1)) ? '0 : gidx_q + IDX_W'(1);
  assign idle_pick = rr_pick(ptr_q, req_idx);
  assign rel_pick  = rr_pick(nxt_ptr, req_idx);
  assign fire_o    = (state_q == ST_LOCKED) & req_idx[gidx_q] & out_ready_i;

  // Release priority: tail fire, then abort, then watchdog.
  always_comb begin
    rel         = 1'b0;
    rel_timeout = 1'b0;
    if (state_q == ST_LOCKED) begin
      if (fire_o && tail_i) begin
        rel = 1'b1;
      end else if (!req_idx[gidx_q]) begin
        rel = 1'b1;
      end else if (hcnt_q == CNT_W'(HOLD_MAX-1)) begin
        rel         = 1'b1;
        rel_timeout = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    hcnt_d    = hcnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (idle_pick[IDX_W]) begin
          state_d = ST_LOCKED;
          gidx_d  = idle_pick[IDX_W-1:0];
          hcnt_d  = '0;
        end
      end
      ST_LOCKED: begin
        if (rel) begin
          ptr_d     = nxt_ptr;
          timeout_d = rel_timeout;
          if (rel_pick[IDX_W]) begin
            gidx_d = rel_pick[IDX_W-1:0];
            hcnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hcnt_d = hcnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_LOCKED);
    grant_d = valid_d ? (NUM_IN'(5'b10000) >> gidx_d) : '0;
    sel_d   = valid_d ? gidx_d : '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      hcnt_q    <= '0;
      grant_q   <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      hcnt_q    <= hcnt_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_sel_o   = sel_q;
  assign grant_valid_o = valid_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_noc_output_rr_arbiter.sv
// Bench for noc_output_rr_arbiter: directed scenarios plus random traffic,
// checked against a packet-level reference model.
module tb_noc_output_rr_arbiter;

  localparam int unsigned HOLD_MAX = 8;
  localparam int unsigned CNT_W    = 4;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [4:0] req_i;
  logic       tail_i;
  logic       out_ready_i;
  logic [4:0] grant_o;
  logic [2:0] grant_sel_o;
  logic       grant_valid_o;
  logic       fire_o;
  logic       timeout_o;

  noc_output_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .req_i        (req_i),
    .tail_i       (tail_i),
    .out_ready_i  (out_ready_i),
    .grant_o      (grant_o),
    .grant_sel_o  (grant_sel_o),
    .grant_valid_o(grant_valid_o),
    .fire_o       (fire_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  logic obs_fire;

  // Reference model: who owns the port, how long it has held it, and
  // which input has top priority next.
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_to;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit wants(input logic [4:0] r, input int k);
    return (k >= 0 && k < 5) ? bit'(r[4-k]) : 1'b0;
  endfunction

  function automatic int first_from(input int p, input logic [4:0] r);
    for (int o = 0; o < 5; o++) begin
      if (wants(r, (p + o) % 5)) return (p + o) % 5;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = -1; m_ptr = 0; m_held = 0; m_to = 0;
  endtask

  task automatic model_update(input logic [4:0] r, input logic t, input logic rdy);
    int  w;
    bit  done;
    m_to = 0;
    if (!m_locked) begin
      w = first_from(m_ptr, r);
      if (w >= 0) begin m_locked = 1; m_owner = w; m_held = 0; end
    end else begin
      done = 0;
      if (wants(r, m_owner) && rdy && t) done = 1;
      else if (!wants(r, m_owner)) done = 1;
      else if (m_held + 1 >= HOLD_MAX) begin done = 1; m_to = 1; end
      if (done) begin
        m_ptr = (m_owner + 1) % 5;
        w = first_from(m_ptr, r);
        if (w >= 0) begin m_owner = w; m_held = 0; end
        else begin m_locked = 0; m_owner = -1; end
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("grant", grant_o, m_locked ? (32'h10 >> m_owner) : 32'h0);
    check_eq("sel", grant_sel_o, m_locked ? m_owner : 0);
    check_eq("valid", grant_valid_o, m_locked);
    check_eq("timeout", timeout_o, m_to);
  endtask

  // Called at a falling edge: drive, check fire, clock, check registered outputs.
  task automatic step(input logic [4:0] r, input logic t, input logic rdy);
    req_i = r; tail_i = t; out_ready_i = rdy;
    #1;
    obs_fire = fire_o;
    check_eq("fire", fire_o, m_locked && wants(r, m_owner) && rdy);
    @(posedge clk_i);
    model_update(r, t, rdy);
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    #1;
    check_eq("rst_grant", grant_o, 0);
    check_eq("rst_sel", grant_sel_o, 0);
    check_eq("rst_valid", grant_valid_o, 0);
    check_eq("rst_fire", fire_o, 0);
    check_eq("rst_timeout", timeout_o, 0);
    model_reset();
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  initial begin
    req_i = '0; tail_i = 0; out_ready_i = 0; rst_n_i = 0;
    do_reset();

    // Mid-packet reset with E granted, then N wins a full request.
    step(5'b00010, 0, 1);
    check_eq("e_sel", grant_sel_o, 3);
    step(5'b00010, 0, 1);
    do_reset();
    step(5'b11111, 0, 1);
    check_eq("after_rst_sel", grant_sel_o, 0);

    // Rotation with single-flit packets from everyone.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(5'b11111, 1, 1);
      check_eq("rot_sel", grant_sel_o, i % 5);
      check_eq("rot_fire", obs_fire, i > 0);
    end

    // Lock: W sends 4 flits while N requests; N follows.
    do_reset();
    step(5'b00100, 0, 1);
    for (int s = 1; s <= 4; s++) begin
      step(5'b10100, s == 4, 1);
      check_eq("lock_sel", grant_sel_o, s < 4 ? 2 : 0);
    end
    // Same, but E also requests at the release: pointer 3 favours E over N.
    do_reset();
    step(5'b00100, 0, 1);
    for (int s = 1; s <= 3; s++) step(5'b10100, 0, 1);
    step(5'b10110, 1, 1);
    check_eq("ptr3_sel", grant_sel_o, 3);

    // Backpressure: tail during stall does not release.
    do_reset();
    step(5'b00001, 0, 1);
    step(5'b00001, 0, 1);
    for (int s = 0; s < 3; s++) begin
      step(5'b00001, 1, 0);
      check_eq("bp_fire", obs_fire, 0);
      check_eq("bp_sel", grant_sel_o, 4);
    end
    step(5'b10001, 1, 1);
    check_eq("bp_rel_fire", obs_fire, 1);
    check_eq("bp_rel_sel", grant_sel_o, 0);

    // Watchdog: E held exactly HOLD_MAX cycles, L takes over.
    do_reset();
    step(5'b00010, 0, 1);
    for (int s = 1; s <= HOLD_MAX; s++) begin
      step(5'b00011, 0, 1);
      check_eq("to_sel", grant_sel_o, s < HOLD_MAX ? 3 : 4);
      check_eq("to_pulse", timeout_o, s == HOLD_MAX);
    end
    step(5'b00001, 0, 1);
    check_eq("to_pulse_end", timeout_o, 0);

    // Abort: S drops mid-packet, port goes idle, pointer moves to W.
    do_reset();
    step(5'b01000, 0, 1);
    step(5'b01000, 0, 1);
    step(5'b00000, 0, 1);
    check_eq("abort_valid", grant_valid_o, 0);
    check_eq("abort_to", timeout_o, 0);
    step(5'b11111, 0, 1);
    check_eq("abort_ptr_sel", grant_sel_o, 2);

    // Random traffic; the owner usually keeps requesting so packets last.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] r;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        r = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) r = '0;
        if (m_locked && $urandom_range(0, 9) < 8) r[4-m_owner] = 1'b1;
        step(r, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
